// File: rtl/hls_deadlock_detect_unit_thresh.sv
// Per-process deadlock detection node: propagates dependence vectors, forwards report
// tokens and confirms deadlock after DL_THRESH consecutive self-hits. Optional macro: DL_STALL_CNT_EN.
module hls_deadlock_detect_unit_thresh #(
    parameter int unsigned PROC_NUM     = 4,
    parameter int unsigned PROC_ID      = 0,
    parameter int unsigned IN_CHAN_NUM  = 2,
    parameter int unsigned OUT_CHAN_NUM = 3,
    parameter int unsigned DL_THRESH    = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            dl_ack,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_report_vld,
    output logic [PROC_NUM-1:0]             dl_report_dep,
`ifdef DL_STALL_CNT_EN
    output logic [31:0]                     dl_stall_cnt,
`endif
    output logic [1:0]                      dl_state
);

    localparam int unsigned CntW = $clog2(DL_THRESH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DL_THRESH);
    localparam logic [CntW-1:0] CntLast = CntW'(DL_THRESH - 1);
    localparam logic [PROC_NUM-1:0] SelfBit = PROC_NUM'(1) << PROC_ID;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StSuspect   = 2'd1,
        StConfirmed = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [PROC_NUM-1:0]  dep_reg;
    logic [PROC_NUM-1:0]  dep_comb;
    logic [PROC_NUM-1:0]  dep;
    logic                 blocked;
    logic                 gate;
    logic                 self_hit;
    logic                 tok_fwd;
    logic                 entering;

    always_comb begin
        dep_comb = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            dep_comb = dep_comb |
                ({PROC_NUM{in_chan_dep_vld_vec[i]}} & in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]);
        end
    end

    // While a region-level deadlock is flagged, only a passing token refreshes the dependence.
    assign gate     = ~dl_detect_in | (|token_in_vec);
    assign dep      = gate ? dep_comb : dep_reg;
    assign blocked  = |proc_dep_vld_vec;
    assign self_hit = gate & dep[PROC_ID] & blocked;
    assign tok_fwd  = ((|token_in_vec) & ~token_clear) | origin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (self_hit) begin
                    if (DL_THRESH == 1) begin
                        state_d = StConfirmed;
                        cnt_d   = CntMax;
                    end else begin
                        state_d = StSuspect;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StSuspect: begin
                if (!self_hit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StConfirmed;
                    cnt_d   = CntMax;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StConfirmed: begin
                if (!self_hit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign entering = (state_d == StConfirmed) && (state_q != StConfirmed);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            dep_reg       <= '0;
            token_out_vec <= '0;
            dl_detect_out <= 1'b0;
            dl_report_vld <= 1'b0;
            dl_report_dep <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dep_reg       <= blocked ? dep : '0;
            token_out_vec <= tok_fwd ? proc_dep_vld_vec : '0;
            dl_detect_out <= (state_d == StConfirmed);
            // A fresh confirmation overrides a coincident acknowledge.
            if (entering && (!dl_report_vld || dl_ack)) begin
                dl_report_vld <= 1'b1;
                dl_report_dep <= dep | SelfBit;
            end else if (dl_ack) begin
                dl_report_vld <= 1'b0;
            end
        end
    end

`ifdef DL_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (dl_ack) begin
            stall_q <= '0;
        end else if (state_q == StConfirmed && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign dl_stall_cnt = stall_q;
`endif

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SelfBit;
    assign dl_state             = state_q;

endmodule

// File: tb/tb_hls_deadlock_detect_unit_thresh.sv
// Directed plus randomized bench for hls_deadlock_detect_unit_thresh against a run-length
// reference model (deadlock = at least DL_THRESH consecutive self-hit cycles).
module tb_hls_deadlock_detect_unit_thresh;

    localparam int PN = 4;
    localparam int PID = 0;
    localparam int IC = 2;
    localparam int OC = 3;
    localparam int T = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [OC-1:0]     proc_dep_vld_vec = '0;
    logic [IC-1:0]     in_chan_dep_vld_vec = '0;
    logic [IC*PN-1:0]  in_chan_dep_data_vec = '0;
    logic [IC-1:0]     token_in_vec = '0;
    logic              dl_detect_in = 1'b0;
    logic              origin = 1'b0;
    logic              token_clear = 1'b0;
    logic              dl_ack = 1'b0;
    logic [OC-1:0]     out_chan_dep_vld_vec;
    logic [PN-1:0]     out_chan_dep_data;
    logic [OC-1:0]     token_out_vec;
    logic              dl_detect_out;
    logic              dl_report_vld;
    logic [PN-1:0]     dl_report_dep;
    logic [1:0]        dl_state;
`ifdef DL_STALL_CNT_EN
    logic [31:0]       dl_stall_cnt;
`endif

    hls_deadlock_detect_unit_thresh #(
        .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC), .DL_THRESH(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .proc_dep_vld_vec(proc_dep_vld_vec),
        .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
        .in_chan_dep_data_vec(in_chan_dep_data_vec),
        .token_in_vec(token_in_vec),
        .dl_detect_in(dl_detect_in),
        .origin(origin),
        .token_clear(token_clear),
        .dl_ack(dl_ack),
        .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
        .out_chan_dep_data(out_chan_dep_data),
        .token_out_vec(token_out_vec),
        .dl_detect_out(dl_detect_out),
        .dl_report_vld(dl_report_vld),
        .dl_report_dep(dl_report_dep),
`ifdef DL_STALL_CNT_EN
        .dl_stall_cnt(dl_stall_cnt),
`endif
        .dl_state(dl_state)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [PN-1:0] m_dep_reg;
    int            m_run;
    logic [OC-1:0] m_tok;
    logic          m_det;
    logic          m_vld;
    logic [PN-1:0] m_rdep;
    longint        m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dep_reg = '0; m_run = 0; m_tok = '0; m_det = 0;
        m_vld = 0; m_rdep = '0; m_stall = 0;
    endtask

    task automatic check_all();
        logic [1:0] exp_state;
        exp_state = (m_run == 0) ? 2'd0 : (m_run < T) ? 2'd1 : 2'd2;
        chk("dl_state", 32'(dl_state), 32'(exp_state));
        chk("dl_detect_out", 32'(dl_detect_out), 32'(m_det));
        chk("dl_report_vld", 32'(dl_report_vld), 32'(m_vld));
        chk("dl_report_dep", 32'(dl_report_dep), 32'(m_rdep));
        chk("token_out_vec", 32'(token_out_vec), 32'(m_tok));
        chk("out_chan_dep_data", 32'(out_chan_dep_data), 32'(m_dep_reg | PN'(1 << PID)));
        chk("out_chan_dep_vld_vec", 32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));
`ifdef DL_STALL_CNT_EN
        chk("dl_stall_cnt", dl_stall_cnt, 32'(m_stall));
`endif
    endtask

    // One clock: evaluate the model on the current inputs, take the edge, compare.
    task automatic cycle();
        logic [PN-1:0] dc, dep;
        logic gate, blk, hit;
        int nrun;
        dc = '0;
        for (int i = 0; i < IC; i++)
            if (in_chan_dep_vld_vec[i]) dc = dc | in_chan_dep_data_vec[i*PN +: PN];
        gate = !dl_detect_in || (token_in_vec != 0);
        dep  = gate ? dc : m_dep_reg;
        blk  = (proc_dep_vld_vec != 0);
        hit  = gate && dep[PID] && blk;
        nrun = hit ? ((m_run + 1 > T) ? T : m_run + 1) : 0;
        if (nrun >= T && m_run < T && (!m_vld || dl_ack)) begin
            m_vld = 1; m_rdep = dep | PN'(1 << PID);
        end else if (dl_ack) m_vld = 0;
        if (dl_ack) m_stall = 0;
        else if (m_run >= T && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_dep_reg = blk ? dep : '0;
        m_tok = ((((token_in_vec != 0) && !token_clear) || origin) ? proc_dep_vld_vec : '0);
        m_det = (nrun >= T);
        m_run = nrun;
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_reset_state", 32'(dl_state), 32'd0);
        check_all();
        #2;
        reset = 1'b1;
    endtask

    task automatic set_idle();
        proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
        token_in_vec = '0; dl_detect_in = 0; origin = 0; token_clear = 0; dl_ack = 0;
    endtask

    task automatic drive_hit(input logic [PN-1:0] data);
        proc_dep_vld_vec = 3'b001; in_chan_dep_vld_vec = 2'b01;
        in_chan_dep_data_vec = {4'b0000, data}; dl_detect_in = 0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        reset = 1'b1;
        #1;

        // Four consecutive self-hits confirm deadlock
        drive_hit(4'b0001);
        for (int i = 0; i < 4; i++) cycle();
        chk("confirm_state", 32'(dl_state), 32'd2);
        chk("confirm_rdep", 32'(dl_report_dep), 32'b0001);
        dl_ack = 1; cycle(); dl_ack = 0;

        // Interrupted run restarts the count
        set_idle(); cycle();
        drive_hit(4'b0001); cycle(); cycle();
        proc_dep_vld_vec = '0; cycle();
        chk("drop_state", 32'(dl_state), 32'd0);
        drive_hit(4'b0001);
        for (int i = 0; i < 3; i++) cycle();
        chk("not_yet_detect", 32'(dl_detect_out), 32'd0);
        cycle();
        chk("late_detect", 32'(dl_detect_out), 32'd1);

        // Held report not overwritten, then ack coincident with re-entry recaptures
        set_idle(); cycle();
        drive_hit(4'b0011);
        for (int i = 0; i < 4; i++) cycle();
        chk("held_rdep", 32'(dl_report_dep), 32'b0001);
        set_idle(); cycle();
        drive_hit(4'b0011);
        for (int i = 0; i < 3; i++) cycle();
        dl_ack = 1; cycle(); dl_ack = 0;
        chk("recapture_vld", 32'(dl_report_vld), 32'd1);
        chk("recapture_rdep", 32'(dl_report_dep), 32'b0011);

        // Gated dependence and token forwarding
        set_idle(); cycle();
        drive_hit(4'b0100); cycle();
        dl_detect_in = 1; in_chan_dep_data_vec = 8'h01; cycle();
        chk("gated_dep", 32'(out_chan_dep_data), 32'b0101);
        chk("gated_detect", 32'(dl_detect_out), 32'd0);
        token_in_vec = 2'b10; proc_dep_vld_vec = 3'b101; cycle();
        chk("token_fwd", 32'(token_out_vec), 32'b101);
        token_clear = 1; cycle();
        chk("token_clear", 32'(token_out_vec), 32'd0);
        origin = 1; proc_dep_vld_vec = 3'b110; cycle();
        chk("origin_override", 32'(token_out_vec), 32'b110);

        // Long confirmed stretch, then asynchronous reset
        set_idle(); cycle();
        drive_hit(4'b0001);
        for (int i = 0; i < 14; i++) cycle();
        pulse_reset();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            proc_dep_vld_vec = ($urandom_range(0, 9) < 8) ? OC'($urandom_range(1, 7)) : '0;
            in_chan_dep_vld_vec = IC'($urandom_range(0, 3));
            in_chan_dep_data_vec = IC*PN'($urandom);
            if ($urandom_range(0, 3) != 0) in_chan_dep_data_vec[PID] = 1'b1;
            dl_detect_in = ($urandom_range(0, 4) == 0);
            token_in_vec = IC'($urandom_range(0, 3));
            origin = ($urandom_range(0, 9) == 0);
            token_clear = ($urandom_range(0, 2) == 0);
            dl_ack = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
